// File: rtl/spart.sv
// Special-purpose UART: 4-register tri-state bus interface, shared baud
// generator (16x oversampling), independent TX and RX state machines.
module spart #(
  parameter logic [15:0] DB_RESET = 16'd324
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic       wr, rd;
  logic [7:0] rd_data;
  logic [7:0] rx_buf_q, rx_buf_d;

  assign wr      = iocs & ~iorw;
  assign rd      = iocs & iorw;
  assign rd_data = ioaddr[0] ? {6'b0, tbr, rda} : rx_buf_q;
  assign databus = (rd & ~ioaddr[1]) ? rd_data : 8'hzz;

  // Baud generator: a divisor write restarts the period from the new value
  logic [15:0] db_q, db_d, cnt_q, cnt_d;
  logic        en;

  always_comb begin
    db_d = db_q;
    if (wr && ioaddr == 2'b10) db_d[7:0]  = databus;
    if (wr && ioaddr == 2'b11) db_d[15:8] = databus;
    en = (cnt_q == 16'd0);
    if (wr && ioaddr[1]) cnt_d = db_d;
    else if (en)         cnt_d = db_q;
    else                 cnt_d = cnt_q - 16'd1;
  end

  tx_state_e  tx_q, tx_d;
  logic [9:0] tx_sh_q, tx_sh_d;
  logic [3:0] tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;

  always_comb begin
    tx_d      = tx_q;
    tx_sh_d   = tx_sh_q;
    tx_tick_d = tx_tick_q;
    tx_bit_d  = tx_bit_q;
    case (tx_q)
      TX_IDLE: if (wr && ioaddr == 2'b00) begin
        tx_sh_d   = {1'b1, databus, 1'b0};
        tx_tick_d = 4'd0;
        tx_bit_d  = 4'd0;
        tx_d      = TX_SHIFT;
      end
      TX_SHIFT: if (en) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == 4'd9) tx_d = TX_IDLE;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  assign txd = (tx_q == TX_SHIFT) ? tx_sh_q[0] : 1'b1;
  assign tbr = (tx_q == TX_IDLE);

  rx_state_e  rx_q, rx_d;
  logic       s1_q, s2_q, prev_q;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rda_q, rda_d, done_ok;

  // Samples land mid-bit: 8 ticks into the start bit, then every 16
  always_comb begin
    rx_d      = rx_q;
    rx_tick_d = rx_tick_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    done_ok   = 1'b0;
    case (rx_q)
      RX_IDLE: if (prev_q && !s2_q) begin
        rx_d      = RX_START;
        rx_tick_d = 4'd0;
      end
      RX_START: if (en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd7) begin
          rx_tick_d = 4'd0;
          rx_bit_d  = 3'd0;
          rx_d      = s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd15) begin
          rx_sh_d  = {s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_d = RX_STOP;
        end
      end
      RX_STOP: if (en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd15) begin
          done_ok = s2_q;
          rx_d    = RX_IDLE;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
    rx_buf_d = done_ok ? rx_sh_q : rx_buf_q;
    rda_d    = rda_q;
    if (rd && ioaddr == 2'b00) rda_d = 1'b0;
    if (done_ok)               rda_d = 1'b1;
  end

  assign rda = rda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= DB_RESET;
      cnt_q     <= DB_RESET;
      tx_q      <= TX_IDLE;
      tx_sh_q   <= 10'h3ff;
      tx_tick_q <= 4'd0;
      tx_bit_q  <= 4'd0;
      rx_q      <= RX_IDLE;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      prev_q    <= 1'b1;
      rx_tick_q <= 4'd0;
      rx_bit_q  <= 3'd0;
      rx_sh_q   <= 8'h00;
      rx_buf_q  <= 8'h00;
      rda_q     <= 1'b0;
    end else begin
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      tx_sh_q   <= tx_sh_d;
      tx_tick_q <= tx_tick_d;
      tx_bit_q  <= tx_bit_d;
      rx_q      <= rx_d;
      s1_q      <= rxd;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      rx_tick_q <= rx_tick_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_buf_q  <= rx_buf_d;
      rda_q     <= rda_d;
    end
  end

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart: event-level reference model checked every
// cycle, plus directed literal checks and randomized full-duplex traffic.
module tb_spart;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iocs = 1'b0, iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  wire  [7:0] databus;
  logic       rda, tbr, txd, rxd;
  logic [7:0] bus_drv = 8'h00;
  logic       bus_oe = 1'b1;
  logic       rxd_drv = 1'b1;
  logic       loop = 1'b0;

  assign databus = bus_oe ? bus_drv : 8'hzz;
  assign rxd     = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  spart #(.DB_RESET(16'd324)) dut (
    .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  int passed = 0, total = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (event level) ----------------
  int         m_cyc, m_rel, m_tx_n, m_rx_n;
  logic [15:0] m_db;
  logic       m_tx_busy, m_rx_busy, m_rda;
  logic [9:0] m_tx_frame;
  logic [7:0] m_rx_byte, m_buf;
  logic       m_s1, m_s2, m_prev;

  function automatic logic m_txd();
    return m_tx_busy ? m_tx_frame[m_tx_n / 16] : 1'b1;
  endfunction

  // en fires once per DB+1 clocks, phase set by the last (re)load
  function automatic logic en_at(input int k);
    return ((k - m_rel) % (int'(m_db) + 1)) == int'(m_db);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic en, rxin, mwr, mrd, got;
    if (!rst_n) begin
      m_cyc = 0; m_rel = 0; m_db = 16'd324;
      m_tx_busy = 1'b0; m_tx_n = 0; m_tx_frame = 10'h3ff;
      m_rx_busy = 1'b0; m_rx_n = 0; m_rx_byte = 8'h00;
      m_buf = 8'h00; m_rda = 1'b0;
      m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1;
    end else begin
      en   = en_at(m_cyc);
      rxin = loop ? m_txd() : rxd_drv;
      mwr  = iocs & ~iorw;
      mrd  = iocs & iorw;
      got  = 1'b0;
      if (m_tx_busy) begin
        if (en) m_tx_n++;
        if (m_tx_n == 160) m_tx_busy = 1'b0;
      end else if (mwr && ioaddr == 2'b00) begin
        m_tx_busy = 1'b1; m_tx_frame = {1'b1, bus_drv, 1'b0}; m_tx_n = 0;
      end
      if (!m_rx_busy) begin
        if (m_prev && !m_s2) begin m_rx_busy = 1'b1; m_rx_n = 0; end
      end else if (en) begin
        m_rx_n++;
        if (m_rx_n == 8) begin
          if (m_s2) m_rx_busy = 1'b0;
        end else if (m_rx_n >= 24 && m_rx_n <= 136 && (m_rx_n - 24) % 16 == 0) begin
          m_rx_byte[(m_rx_n - 24) / 16] = m_s2;
        end else if (m_rx_n == 152) begin
          got = m_s2;
          m_rx_busy = 1'b0;
        end
      end
      if (mrd && ioaddr == 2'b00) m_rda = 1'b0;
      if (got) begin m_rda = 1'b1; m_buf = m_rx_byte; end
      m_prev = m_s2; m_s2 = m_s1; m_s1 = rxin;
      if (mwr && ioaddr == 2'b10) begin m_db[7:0]  = bus_drv; m_rel = m_cyc + 1; end
      if (mwr && ioaddr == 2'b11) begin m_db[15:8] = bus_drv; m_rel = m_cyc + 1; end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_txd_c", txd, 1'b1);
      chk1("rst_tbr_c", tbr, 1'b1);
      chk1("rst_rda_c", rda, 1'b0);
    end else begin
      chk1("txd", txd, m_txd());
      chk1("tbr", tbr, !m_tx_busy);
      chk1("rda", rda, m_rda);
      if (iocs && iorw && !ioaddr[1])
        chk8("rdbus", databus, ioaddr[0] ? {6'b0, !m_tx_busy, m_rda} : m_buf);
      else
        chk8("bus_released", databus, bus_drv);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    iocs = cs; iorw = rw; ioaddr = a; bus_drv = d;
    bus_oe = !(cs && rw && !a[1]);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rdreg(input logic [1:0] a);
    bus(1'b1, 1'b1, a, 8'h00);
  endtask

  task automatic wait_tbr(input int budget);
    int n;
    n = 0;
    idle(1);
    while (!tbr && n < budget) begin idle(1); n++; end
    chk1("tbr_timeout", n < budget, 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b, input int bw, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk); #2;
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (bw) @(posedge clk);
      #2;
    end
    rxd_drv = 1'b1;
  endtask

  task automatic send_low(input int n);
    @(posedge clk); #2 rxd_drv = 1'b0;
    repeat (n) @(posedge clk);
    #2 rxd_drv = 1'b1;
  endtask

  task automatic rand_phase(input int db);
    int bw, len;
    bw  = 16 * (db + 1);
    len = 11 * bw + 40;
    wr(2'b10, 8'(db)); wr(2'b11, 8'h00);
    fork
      begin
        if ($urandom_range(0, 5) == 0) send_low($urandom_range(2, 40));
        else send_rx(8'($urandom),
                     bw + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) - 3 : 0),
                     $urandom_range(0, 5) != 0);
        repeat ($urandom_range(1, 20)) @(posedge clk);
      end
      begin
        for (int c = 0; c < len; c++) begin
          int r;
          r = $urandom_range(0, 19);
          if (r < 12)      idle(1);
          else if (r < 15) rdreg(2'($urandom_range(0, 3)));
          else if (r < 18) wr(2'b00, 8'($urandom));
          else             wr(2'b01, 8'($urandom));
        end
      end
    join
  endtask

  logic [9:0] a5_bits;

  initial begin
    a5_bits = 10'b1101001010;   // {stop, 8'hA5, start}, LSB sent first
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rdreg(2'b01); #2 chk8("rst_status", databus, 8'h02);
    rdreg(2'b00); #2 chk8("rst_rxbuf", databus, 8'h00);
    wr(2'b10, 8'h03); wr(2'b11, 8'h00);
    idle(4);

    // TX frame A5 with 64-clock bits; a second write mid-frame is dropped
    wr(2'b00, 8'hA5);
    idle(1); #2 chk1("tbr_low", tbr, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) idle(32);
      else if (i == 3) begin wr(2'b00, 8'hFF); idle(63); end
      else idle(64);
      #2 chk1($sformatf("tx_bit%0d", i), txd, a5_bits[i]);
    end
    idle(22); #2 chk1("tbr_busy_630", tbr, 1'b0);
    idle(15); #2 chk1("tbr_done_645", tbr, 1'b1);

    // RX 3C while transmitting (full duplex)
    fork
      send_rx(8'h3C, 64, 1'b1);
      begin wr(2'b00, 8'($urandom)); idle(700); end
    join
    #2 chk1("rx_rda", rda, 1'b1);
    rdreg(2'b00); #2 chk8("rx_data", databus, 8'h3C);
    idle(1); #2 chk1("rx_rda_clr", rda, 1'b0);

    // glitch, then framing error
    fork send_low(20); idle(300); join
    #2 chk1("glitch_rda", rda, 1'b0);
    fork send_rx(8'h99, 64, 1'b0); idle(700); join
    #2 chk1("frame_rda", rda, 1'b0);
    rdreg(2'b00); #2 chk8("frame_buf", databus, 8'h3C);
    idle(2);

    for (int it = 0; it < 24; it++) rand_phase($urandom_range(0, 3));

    // loopback with overrun
    idle(800);
    wr(2'b10, 8'h03); wr(2'b11, 8'h00);
    rdreg(2'b00);
    loop = 1'b1;
    wr(2'b00, 8'h55); wait_tbr(2000);
    wr(2'b00, 8'hAA); wait_tbr(2000);
    idle(100);
    #2 chk1("loop_rda", rda, 1'b1);
    rdreg(2'b00); #2 chk8("loop_buf", databus, 8'hAA);

    // async reset mid-frame (txd is low during data bit 0 of F0)
    wr(2'b00, 8'hF0);
    idle(100);
    #2 rst_n = 1'b0;
    #1 chk1("rst_txd", txd, 1'b1);
    chk1("rst_tbr", tbr, 1'b1);
    chk1("rst_rda", rda, 1'b0);
    loop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rdreg(2'b01); #2 chk8("rst2_status", databus, 8'h02);
    rdreg(2'b00); #2 chk8("rst2_rxbuf", databus, 8'h00);
    idle(5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spart.md
Name: spart

Overview:
- Special-purpose UART sitting directly downstream of the bus driver.
- Exposes a 4-address register interface on a shared 8-bit tri-state databus.
- Serialises transmit bytes onto txd and deserialises rxd into a receive buffer.
- Provides rda/tbr status back to the driver and a programmable 16-bit baud divisor.

Parameters:
- DB_RESET, 16'd324, divisor loaded at reset (50 MHz clk, 9600 baud, 16x oversampling).

Ports:
- clk  input  1  system clock
- rst_n  input  1  async active-low reset
- iocs  input  1  chip select; the bus is ignored when low
- iorw  input  1  1 = read from SPART, 0 = write to SPART
- ioaddr  input  2  register select
- databus  inout  8  shared data bus
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state is flopped on posedge clk.
- Register map:
  - 00 rd: rx buffer.
  - 00 wr: tx data.
  - 01 rd: status {6'b0, tbr, rda}.
  - 01 wr: ignored.
  - 10 wr: DB low.
  - 11 wr: DB high.
  - 10/11 rd: bus not driven.
- databus is driven only when iocs & iorw & ioaddr[1]==0; it is high-Z otherwise. This is combinational: data is valid in the same cycle as the request.
- Writes are sampled at posedge when iocs & !iorw.
- Reset values:
  - txd=1, tbr=1, rda=0, rx buffer=8'h00.
  - DB=DB_RESET.
  - Baud counter=DB_RESET.
  - TX and RX FSMs in IDLE.
- Baud generator:
  - 16-bit down-counter.
  - At 0 it emits a 1-cycle en pulse and reloads DB. en period = DB+1 clocks.
  - A write to DB low or DB high reloads the counter with the new DB value on the next cycle.
  - DB=0 gives en every cycle.
- TX FSM: IDLE -> SHIFT.
  - A write to 00 in IDLE loads a 10-bit frame {1 stop, data[7:0], 0 start} and enters SHIFT.
  - tbr goes low the cycle after the write.
  - txd presents the current LSB; the frame shifts once every 16 en pulses.
  - After 10 bits it returns to IDLE, and tbr returns high in the same cycle.
  - A write to 00 while tbr=0 is dropped.
- RX path:
  - rxd passes through a 2-flop synchroniser (resets to 1).
  - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronised falling edge moves to START and clears the en counter.
  - START: after 8 en pulses, sample rxd. If 1 (glitch), return to IDLE. If 0, go to DATA.
  - DATA: sample every 16 en pulses, LSB first, 8 bits.
  - STOP: sample after 16 en pulses.
    - Stop bit=1: write the byte to the rx buffer and set rda=1 next cycle.
    - Stop bit=0 (framing error): discard the byte; rda and the buffer are unchanged.
    - In both cases, return to IDLE.
- rda clear: a read of 00 (iocs & iorw & ioaddr==00) clears rda the next cycle.
- Simultaneous events:
  - A valid stop completing in the same cycle as a read of 00 gives rda=1 and buffer=new byte; the read returns the old byte.
  - Overrun (new byte while rda=1): the buffer is overwritten and rda stays 1.
- Reset mid-frame: both FSMs abort immediately, txd=1, and all outputs return to reset values.
- TX and RX are fully independent; full-duplex operation is required.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-TX.
  - Response: txd=1, tbr=1, rda=0 immediately, with no clock required. After release, read 01 returns 8'h02.
- Divisor program:
  - Stimulus: write 10<=8'h03, then 11<=8'h00.
  - Response: en pulses every 4 clocks, giving 64 clocks per bit.
- TX frame:
  - Stimulus: with DB=3, write 00<=8'hA5.
  - Response: tbr=0 next cycle. txd sequence is 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks wide. tbr=1 after 640 clocks. A second write during the frame is dropped.
- RX frame:
  - Stimulus: drive rxd with 8'h3C, 64 clocks per bit.
  - Response: rda=1 after the stop bit. Read 00 returns 8'h3C and rda=0 on the following cycle.
- Glitch and framing error:
  - Stimulus 1: a rxd low pulse of 20 clocks.
  - Response 1: no reception.
  - Stimulus 2: a frame with stop=0.
  - Response 2: rda stays 0 and the buffer is unchanged.
- Loopback and overrun:
  - Stimulus: tie txd to rxd, write 8'h55, then 8'hAA without reading.
  - Response: rda=1, buffer=8'hAA. The bus is high-Z whenever iorw=0 or iocs=0.
